// File: rtl/complete_bus_arbiter_if.sv
// Complete-stage bus between the FU result sources and the ROB/UIQ complete ports.
// The arbiter connects through the master modport; the result sources and ROB side use slave.
interface complete_bus_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int N_PORTS = 2,
    parameter int DW      = 32,
    parameter int PRW     = 6
);
    logic                   flush;
    logic                   rob_stall;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*DW-1:0]    req_data;
    logic [N_REQ*DW-1:0]    req_pc;
    logic [N_REQ*PRW-1:0]   req_dr;
    logic [N_REQ-1:0]       req_ready;
    logic [N_PORTS-1:0]     cpl_valid;
    logic [N_PORTS*DW-1:0]  cpl_data;
    logic [N_PORTS*DW-1:0]  cpl_pc;
    logic [N_PORTS*PRW-1:0] cpl_dr;

    modport master (
        input  flush, rob_stall, req_valid, req_data, req_pc, req_dr,
        output req_ready, cpl_valid, cpl_data, cpl_pc, cpl_dr
    );

    modport slave (
        output flush, rob_stall, req_valid, req_data, req_pc, req_dr,
        input  req_ready, cpl_valid, cpl_data, cpl_pc, cpl_dr
    );
endinterface

// File: rtl/complete_bus_arbiter.sv
// Round-robin arbiter granting up to N_PORTS finished FU results per cycle onto
// registered ROB complete / UIQ wakeup ports (one cycle of latency).
module complete_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_PORTS = 2,
    parameter int DW      = 32,
    parameter int PRW     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    complete_bus_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   port_src [N_PORTS];
    logic [N_PORTS-1:0] port_hit;
    logic [N_REQ-1:0]   grant;
    int                 n_gnt;

    // Scan from rr_ptr; the i-th valid requester found lands on port i.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant    = '0;
        port_hit = '0;
        rr_next  = rr_ptr;
        n_gnt    = 0;
        for (int p = 0; p < N_PORTS; p++) port_src[p] = '0;
        if (!rst && !bus.flush && !bus.rob_stall) begin
            for (int i = 0; i < N_REQ; i++) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (k == (int'(rr_ptr) + i) % N_REQ && bus.req_valid[k] && n_gnt < N_PORTS) begin
                        grant[k] = 1'b1;
                        for (int p = 0; p < N_PORTS; p++) begin
                            if (p == n_gnt) begin
                                port_hit[p] = 1'b1;
                                port_src[p] = PTR_W'(k);
                            end
                        end
                        n_gnt   = n_gnt + 1;
                        rr_next = PTR_W'((k + 1) % N_REQ);
                    end
                end
            end
        end
    end

    assign bus.req_ready = grant;

    // Stall and flush suppress every grant, so port_hit alone clears the valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.cpl_valid <= '0;
            bus.cpl_data  <= '0;
            bus.cpl_pc    <= '0;
            bus.cpl_dr    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            bus.cpl_valid <= port_hit;
            if (|grant) rr_ptr <= rr_next;
            for (int p = 0; p < N_PORTS; p++) begin
                if (port_hit[p]) begin
                    bus.cpl_data[p*DW +: DW]  <= bus.req_data[int'(port_src[p])*DW +: DW];
                    bus.cpl_pc[p*DW +: DW]    <= bus.req_pc[int'(port_src[p])*DW +: DW];
                    bus.cpl_dr[p*PRW +: PRW]  <= bus.req_dr[int'(port_src[p])*PRW +: PRW];
                end
            end
        end
    end
endmodule
